// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline controller.
// State encoding and register index helpers.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Data-memory request/acknowledge handshake.
// The controller is master; the memory side is slave.
interface pipe_ctrl_if;

  logic mem_req;
  logic mem_ack;

  modport master (
    output mem_req,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    output mem_ack
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID/EX load
// and the sources of the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic     idex_memread_i,
  input  reg_idx_t idex_rt_i,
  input  reg_idx_t ifid_rs_i,
  input  reg_idx_t ifid_rt_i,
  output logic     load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (idex_rt_i == ifid_rs_i);
  assign rt_hit = (idex_rt_i == ifid_rt_i);

  assign load_use_o = idex_memread_i
                    && (idex_rt_i != REG_ZERO)
                    && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stage enables, flushes,
// load-use/branch handling and memory access sequencing.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  reg_idx_t         IDEX_RegRt,
  input  reg_idx_t         IFID_RegRs,
  input  reg_idx_t         IFID_RegRt,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic             branch_taken,
  pipe_ctrl_if.master      mem,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MEMWBBubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             req_q, req_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic mem_op;
  logic freeze;
  logic load_use;
  logic lu_sel;

  hazard_detect u_hz (
    .idex_memread_i (IDEX_MemRead),
    .idex_rt_i      (IDEX_RegRt),
    .ifid_rs_i      (IFID_RegRs),
    .ifid_rt_i      (IFID_RegRt),
    .load_use_o     (load_use)
  );

  assign mem_op = EXMEM_MemRead | EXMEM_MemWrite;

  assign freeze = (state_q == WAIT)
               || (state_q == ERR)
               || ((state_q == RUN) && mem_op);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    req_d   = req_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_op) begin
          state_d = WAIT;
          req_d   = 1'b1;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        // ack wins over a timeout landing in the same cycle
        if (mem.mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          tmo_d   = '0;
        end else if (tmo_q == TMAX) begin
          state_d = ERR;
          req_d   = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        state_d = RUN;
      end
      ERR: begin
        req_d = 1'b0;
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign lu_sel = load_use && !branch_taken;

  always_comb begin
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    IDEXWrite   = 1'b0;
    EXMEMWrite  = 1'b0;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MEMWBBubble = 1'b1;
    if (!rst && !freeze) begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IDEXWrite   = 1'b1;
      EXMEMWrite  = 1'b1;
      MEMWBBubble = 1'b0;
      unique case (1'b1)
        branch_taken: begin
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
        end
        lu_sel: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!PCWrite && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= RUN;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign mem.mem_req = req_q;
  assign mem_err     = err_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table for
// hazard/branch decode plus memory-access sequences.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int TO = 4;
  localparam int CW = 16;

  // {PCWrite,IFIDWrite,IDEXWrite,EXMEMWrite,IFIDFlush,IDEXFlush,MEMWBBubble}
  localparam logic [6:0] C_RUN = 7'b1111000;
  localparam logic [6:0] C_LU  = 7'b0011010;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_FRZ = 7'b0000001;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic IDEX_MemRead = 1'b0;
  reg_idx_t IDEX_RegRt = '0;
  reg_idx_t IFID_RegRs = '0;
  reg_idx_t IFID_RegRt = '0;
  logic EXMEM_MemRead = 1'b0;
  logic EXMEM_MemWrite = 1'b0;
  logic branch_taken = 1'b0;

  logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic IFIDFlush, IDEXFlush, MEMWBBubble, mem_err;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl_if mif ();

  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock          (clock),
    .rst            (rst),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_RegRt     (IDEX_RegRt),
    .IFID_RegRs     (IFID_RegRs),
    .IFID_RegRt     (IFID_RegRt),
    .EXMEM_MemRead  (EXMEM_MemRead),
    .EXMEM_MemWrite (EXMEM_MemWrite),
    .branch_taken   (branch_taken),
    .mem            (mif.master),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEXWrite      (IDEXWrite),
    .EXMEMWrite     (EXMEMWrite),
    .IFIDFlush      (IFIDFlush),
    .IDEXFlush      (IDEXFlush),
    .MEMWBBubble    (MEMWBBubble),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      nm;
    logic [6:0] ctl;
    logic       req;
    logic       err;
  } exp_t;

  typedef struct {
    string      nm;
    logic       mr;
    logic [4:0] rt;
    logic [4:0] rs;
    logic [4:0] rtid;
    logic       br;
    logic [6:0] ctl;
  } vec_t;

  exp_t sbq[$];
  int nchk = 0;
  int nerr = 0;
  int sc_model = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic [6:0] ctl,
                      input logic rq, input logic er);
    exp_t e;
    logic [6:0] act;
    e.nm = nm; e.ctl = ctl; e.req = rq; e.err = er;
    sbq.push_back(e);
    @(negedge clock);
    e = sbq.pop_front();
    act = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
           IFIDFlush, IDEXFlush, MEMWBBubble};
    cmp({e.nm, ".ctl"}, int'(act), int'(e.ctl));
    cmp({e.nm, ".req"}, int'(mif.mem_req), int'(e.req));
    cmp({e.nm, ".err"}, int'(mem_err), int'(e.err));
    cmp({e.nm, ".cnt"}, int'(stall_cnt), sc_model);
    if (rst) sc_model = 0;
    else if (!e.ctl[6]) sc_model++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    IDEX_MemRead = 0; IDEX_RegRt = 0; IFID_RegRs = 0;
    IFID_RegRt = 0; branch_taken = 0;
    EXMEM_MemRead = 0; EXMEM_MemWrite = 0;
    mif.mem_ack = 0;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{"lu_rs",  1, 5, 5, 0, 0, C_LU};
    vt[1] = '{"lu_rt",  1, 7, 1, 7, 0, C_LU};
    vt[2] = '{"r0",     1, 0, 0, 0, 0, C_RUN};
    vt[3] = '{"noload", 0, 5, 5, 5, 0, C_RUN};
    vt[4] = '{"br_lu",  1, 5, 5, 0, 1, C_BR};
    vt[5] = '{"br",     0, 0, 3, 4, 1, C_BR};
    vt[6] = '{"nomatch",1, 6, 3, 4, 0, C_RUN};

    idle();
    rst = 1;
    @(posedge clock); #1;
    step("rst0", C_FRZ, 0, 0);
    step("rst1", C_FRZ, 0, 0);
    rst = 0;
    step("idle", C_RUN, 0, 0);

    foreach (vt[i]) begin
      IDEX_MemRead = vt[i].mr;
      IDEX_RegRt   = vt[i].rt;
      IFID_RegRs   = vt[i].rs;
      IFID_RegRt   = vt[i].rtid;
      branch_taken = vt[i].br;
      step(vt[i].nm, vt[i].ctl, 0, 0);
    end
    idle();

    mif.mem_ack = 1;
    step("ack_idle", C_RUN, 0, 0);
    mif.mem_ack = 0;

    // load with ack on the last allowed WAIT cycle
    EXMEM_MemRead = 1;
    step("ld_run", C_FRZ, 0, 0);
    for (int k = 0; k < TO; k++) begin
      mif.mem_ack = (k == TO - 1);
      branch_taken = 1;
      step("ld_wait", C_FRZ, 1, 0);
    end
    mif.mem_ack = 0;
    branch_taken = 0;
    step("ld_done", C_RUN, 0, 0);
    EXMEM_MemRead = 0;
    step("ld_after", C_RUN, 0, 0);

    // early ack, branch in DONE, back-to-back access
    EXMEM_MemWrite = 1;
    step("st_run", C_FRZ, 0, 0);
    mif.mem_ack = 1;
    step("st_wait", C_FRZ, 1, 0);
    mif.mem_ack = 0;
    branch_taken = 1;
    step("st_done", C_BR, 0, 0);
    branch_taken = 0;
    step("b2b_run", C_FRZ, 0, 0);
    step("b2b_w0", C_FRZ, 1, 0);
    mif.mem_ack = 1;
    step("b2b_w1", C_FRZ, 1, 0);
    mif.mem_ack = 0;
    IDEX_MemRead = 1; IDEX_RegRt = 9; IFID_RegRt = 9;
    step("b2b_done", C_LU, 0, 0);
    idle();
    step("b2b_idle", C_RUN, 0, 0);

    // timeout into ERR
    EXMEM_MemWrite = 1;
    step("to_run", C_FRZ, 0, 0);
    for (int k = 0; k < TO; k++) begin
      step("to_wait", C_FRZ, 1, 0);
    end
    step("to_err0", C_FRZ, 0, 1);
    EXMEM_MemWrite = 0;
    branch_taken = 1;
    step("to_err1", C_FRZ, 0, 1);
    branch_taken = 0;
    mif.mem_ack = 1;
    step("to_late", C_FRZ, 0, 1);
    mif.mem_ack = 0;
    step("to_err2", C_FRZ, 0, 1);
    rst = 1;
    step("to_rst", C_FRZ, 0, 1);
    rst = 0;
    step("to_clr", C_RUN, 0, 0);

    // reset in the middle of WAIT
    EXMEM_MemRead = 1;
    step("mr_run", C_FRZ, 0, 0);
    step("mr_w0", C_FRZ, 1, 0);
    rst = 1;
    step("mr_rst", C_FRZ, 1, 0);
    rst = 0;
    EXMEM_MemRead = 0;
    step("mr_run2", C_RUN, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
